rx_frame_parser: RTL

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

---
 rtl/rx_frame_parser.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rx_frame_parser.sv
// Byte-stream frame parser: hunts SOF, takes fixed or in-band length,
// checks sum and EOF, and streams payloads into round-robin banks.
module rx_frame_parser #(
    parameter int          NBUF       = 2,
    parameter int          SOFLEN     = 2,
    parameter logic [31:0] SOFPATTERN = 32'h0000EB90,
    parameter int          EOFDETECT  = 1,
    parameter int          EOFLEN     = 2,
    parameter logic [31:0] EOFPATTERN = 32'h000090EB,
    parameter int          LENMODE    = 0,
    parameter int          FRAMECNT   = 64,
    parameter int          MAXLEN     = 255,
    parameter int          CHKEN      = 1,
    parameter int          TIMEOUT    = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            rx_data_valid,
    input  logic [7:0]      rx_data,
    input  logic [NBUF-1:0] bank_release,
    output logic [NBUF-1:0] frame_datavld,
    output logic [7:0]      frame_data,
    output logic [10:0]     frame_count,
    output logic [NBUF-1:0] frame_interrupt,
    output logic            frame_error,
    output logic [2:0]      err_code,
    output logic [15:0]     frames_ok
);

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, EOF, DONE} state_t;

    localparam logic [31:0] SOFMASK  = 32'hFFFF_FFFF >> (8 * (4 - SOFLEN));
    localparam logic [31:0] SOFMATCH = SOFPATTERN & SOFMASK;
    localparam logic [7:0]  MAXL     = 8'((MAXLEN > 255) ? 255 : MAXLEN);
    localparam int          GW       = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAPMAX = GW'(TIMEOUT - 1);
    localparam logic [1:0]  LASTBANK = 2'(NBUF - 1);
    localparam logic [1:0]  EOFLAST  = 2'(EOFLEN - 1);
    localparam state_t AFTER_CHK = (EOFDETECT != 0) ? EOF : DONE;
    localparam state_t AFTER_PAY = (CHKEN != 0) ? CHK : AFTER_CHK;

    state_t          state;
    logic [31:0]     win;
    logic [31:0]     win_next;
    logic [31:0]     eof_word;
    logic            sof_hit;
    logic            timed_out;
    logic [1:0]      bank_ptr;
    logic [NBUF-1:0] busy;
    logic [NBUF-1:0] bank_oh;
    logic [10:0]     cnt;
    logic [10:0]     target;
    logic [7:0]      len;
    logic [7:0]      sum;
    logic [7:0]      eof_byte;
    logic [1:0]      eof_idx;
    logic [GW-1:0]   gap;

    always_comb begin
        win_next  = ((win << 8) | {24'd0, rx_data}) & SOFMASK;
        sof_hit   = (win_next == SOFMATCH);
        bank_oh   = NBUF'(1) << bank_ptr;
        target    = (LENMODE != 0) ? {3'd0, len} : 11'(FRAMECNT);
        eof_word  = EOFPATTERN >> {EOFLAST - eof_idx, 3'b000};
        eof_byte  = eof_word[7:0];
        timed_out = (state != HUNT) && (state != DONE) &&
                    !rx_data_valid && (gap == GAPMAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= HUNT;
            win             <= '0;
            bank_ptr        <= '0;
            busy            <= '0;
            cnt             <= '0;
            len             <= '0;
            sum             <= '0;
            eof_idx         <= '0;
            gap             <= '0;
            frame_datavld   <= '0;
            frame_data      <= '0;
            frame_count     <= '0;
            frame_interrupt <= '0;
            frame_error     <= 1'b0;
            err_code        <= '0;
            frames_ok       <= '0;
        end else begin
            frame_datavld   <= '0;
            frame_interrupt <= '0;
            frame_error     <= 1'b0;
            busy            <= busy & ~bank_release;
            if (!enable) begin
                state <= HUNT;
                gap   <= '0;
            end else if (timed_out) begin
                frame_error <= 1'b1;
                err_code    <= 3'd4;
                state       <= HUNT;
            end else begin
                if (state == HUNT || rx_data_valid) gap <= '0;
                else gap <= gap + GW'(1);
                case (state)
                    HUNT: if (rx_data_valid) begin
                        win <= win_next;
                        if (sof_hit) begin
                            win         <= '0;
                            frame_count <= '0;
                            cnt         <= '0;
                            sum         <= '0;
                            eof_idx     <= '0;
                            if (|(busy & bank_oh)) begin
                                frame_error <= 1'b1;
                                err_code    <= 3'd5;
                            end else begin
                                state <= (LENMODE != 0) ? LEN : PAYLOAD;
                            end
                        end
                    end
                    LEN: if (rx_data_valid) begin
                        if (rx_data == 8'd0 || rx_data > MAXL) begin
                            frame_error <= 1'b1;
                            err_code    <= 3'd1;
                            state       <= HUNT;
                        end else begin
                            len   <= rx_data;
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: if (rx_data_valid) begin
                        frame_data    <= rx_data;
                        frame_datavld <= bank_oh;
                        frame_count   <= cnt;
                        cnt           <= cnt + 11'd1;
                        sum           <= sum + rx_data;
                        if (cnt == target - 11'd1) state <= AFTER_PAY;
                    end
                    CHK: if (rx_data_valid) begin
                        if (rx_data != sum) begin
                            frame_error <= 1'b1;
                            err_code    <= 3'd2;
                            state       <= HUNT;
                        end else begin
                            state <= AFTER_CHK;
                        end
                    end
                    EOF: if (rx_data_valid) begin
                        if (rx_data != eof_byte) begin
                            frame_error <= 1'b1;
                            err_code    <= 3'd3;
                            state       <= HUNT;
                        end else if (eof_idx == EOFLAST) begin
                            state <= DONE;
                        end else begin
                            eof_idx <= eof_idx + 2'd1;
                        end
                    end
                    DONE: begin
                        // a release landing on this same cycle leaves the bank free
                        frame_interrupt <= bank_oh;
                        frames_ok       <= frames_ok + 16'd1;
                        busy            <= (busy | bank_oh) & ~bank_release;
                        bank_ptr        <= (bank_ptr == LASTBANK) ? 2'd0
                                                                  : bank_ptr + 2'd1;
                        state           <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
